// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and bypass helper for the multi-port register file
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = 5;
  localparam int REG_ZERO  = 0;

  // The helper works on the widest supported operands; callers zero-extend in and truncate out.
  localparam int MAX_DW = 64;
  localparam int MAX_AW = 16;

  // Port 1 is checked first, so it wins a same-address collision on the bypass path too.
  function automatic logic [MAX_DW-1:0] bypass_read(
    input logic [MAX_AW-1:0] addr,
    input logic [MAX_DW-1:0] stored,
    input logic              we0,
    input logic [MAX_AW-1:0] wa0,
    input logic [MAX_DW-1:0] wd0,
    input logic              we1,
    input logic [MAX_AW-1:0] wa1,
    input logic [MAX_DW-1:0] wd1
  );
    logic [MAX_DW-1:0] result;
    result = stored;
    if (we1 && (wa1 == addr)) begin
      result = wd1;
    end else if (we0 && (wa0 == addr)) begin
      result = wd0;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read, write and scoreboard signals of the register file
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int NRD = 2
);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              bsy_set;
  logic [AW-1:0]     bsy_addr;
  logic              any_busy;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, bsy_set, bsy_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, bsy_set, bsy_addr,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read port: write bypass, busy lookup with clear-bypass, optional output register
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int READ_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    stored,
  input  logic [DEPTH-1:0] busy_vec,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  output logic [DW-1:0]    data,
  output logic             busy
);

  logic [DW-1:0] byp_data;
  logic          byp_busy;
  logic [DW-1:0] data_q;
  logic          busy_q;

  assign byp_data = DW'(bypass_read(MAX_AW'(addr), MAX_DW'(stored),
                                    we0, MAX_AW'(wa0), MAX_DW'(wd0),
                                    we1, MAX_AW'(wa1), MAX_DW'(wd1)));

  // A write landing this cycle retires the pending entry; a same-cycle set is not visible yet.
  assign byp_busy = busy_vec[addr] & ~((we0 && (wa0 == addr)) || (we1 && (wa1 == addr)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= byp_data;
      busy_q <= byp_busy;
    end
  end

  assign data = (READ_REG != 0) ? data_q : byp_data;
  assign busy = (READ_REG != 0) ? busy_q : byp_busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports, bypass and pending-write scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int NRD      = 2,
  parameter int READ_REG = 0,
  parameter int ZERO_R0  = 1
) (
  input logic          clk,
  input logic          rst_n,
  regfile_mp_if.slave  bus
);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             we0_eff;
  logic             we1_eff;
  logic             bsy_set_eff;
  logic [DW-1:0]    rd_data_a [NRD];
  logic             rd_busy_a [NRD];

  // With a hardwired r0 every access to address 0 is dropped before it reaches storage or bypass.
  assign we0_eff     = bus.we0 && !((ZERO_R0 != 0) && (bus.wa0 == AW'(REG_ZERO)));
  assign we1_eff     = bus.we1 && !((ZERO_R0 != 0) && (bus.wa1 == AW'(REG_ZERO)));
  assign bsy_set_eff = bus.bsy_set && !((ZERO_R0 != 0) && (bus.bsy_addr == AW'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we0_eff) begin
        regs[bus.wa0] <= bus.wd0;
      end
      if (we1_eff) begin
        regs[bus.wa1] <= bus.wd1;
      end
    end
  end

  // Clears first, then the set, so a set colliding with a write leaves the register pending.
  always_comb begin
    busy_nxt = busy;
    if (we0_eff) begin
      busy_nxt[bus.wa0] = 1'b0;
    end
    if (we1_eff) begin
      busy_nxt[bus.wa1] = 1'b0;
    end
    if (bsy_set_eff) begin
      busy_nxt[bus.bsy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign bus.any_busy = |busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = bus.rd_addr[k*AW +: AW];

    regfile_rdport #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .READ_REG (READ_REG)
    ) u_rdport (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .stored   (regs[addr]),
      .busy_vec (busy),
      .we0      (we0_eff),
      .wa0      (bus.wa0),
      .wd0      (bus.wd0),
      .we1      (we1_eff),
      .wa1      (bus.wa1),
      .wd1      (bus.wd1),
      .data     (rd_data_a[k]),
      .busy     (rd_busy_a[k])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      bus.rd_data[k*DW +: DW] = rd_data_a[k];
      bus.rd_busy[k]          = rd_busy_a[k];
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the next datapath generation.
- Configurable data width, depth, read-port count and two write ports.
- Same-cycle write-to-read bypass; optional registered read stage.
- Per-register pending-write scoreboard (busy bits) so the hazard unit can detect load-use and multi-cycle writeback dependencies.
- Sits between decode (read ports, busy set) and writeback (write ports).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, 5, address width; equals log2(DEPTH).
- NRD, 2, number of read ports, 1..4.
- READ_REG, 0: 0 = combinational read; 1 = registered read with 1-cycle latency.
- ZERO_R0, 1: 1 = register 0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*DW  read data; port k occupies bits [k*DW +: DW].
- rd_busy  out  NRD  busy bit of the addressed register for each read port.
- we0  in  1  write enable, write port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  DW  write data, port 0.
- we1  in  1  write enable, write port 1.
- wa1  in  AW  write address, port 1.
- wd1  in  DW  write data, port 1.
- bsy_set  in  1  mark a register pending (issued instruction will write it later).
- bsy_addr  in  AW  register to mark pending.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset (rst_n low at a clock edge):
  - All registers become 0 and all busy bits are cleared.
  - When READ_REG=1, the rd_data and rd_busy output registers become 0.
  - any_busy = 0 after reset.
  - Reset takes priority over every write and every bsy_set in the same cycle.
- Writes:
  - An enabled write updates the addressed register at the rising edge.
  - If we0 and we1 are both set and wa0 == wa1, port 1 wins; wd0 is discarded.
- Register 0 when ZERO_R0=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0.
  - Address 0 is never busy; bsy_set with bsy_addr=0 is ignored.
- Bypass: a read in the same cycle as a write to the same address returns the new data (write-first). Port-1 priority also applies to the bypass path.
- READ_REG=0: rd_data and rd_busy are combinational from rd_addr, the stored state and the current-cycle writes (latency 0).
- READ_REG=1:
  - rd_data and rd_busy are registered; the value sampled at edge N reflects rd_addr and the bypassed writes of cycle N-1 (latency 1).
  - The output registers update every cycle; there is no stall input.
- Scoreboard:
  - bsy_set sets busy[bsy_addr] at the edge.
  - Any enabled write to address a clears busy[a] at the edge.
  - If bsy_set and a write target the same address in the same cycle, set wins: the busy bit stays 1 and the register takes the write data.
  - rd_busy reflects the busy bits after the same-cycle clear is applied (clear-bypass) but does not include a same-cycle set.
- Out-of-range addresses: none; DEPTH is a power of two, so every address is valid.
- No other state and no FSM beyond the storage array, busy vector and optional output registers.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW, DEPTH and AW constants;
  - the REG_ZERO address constant;
  - a function that computes the bypassed read value from (addr, stored value, we0, wa0, wd0, we1, wa1, wd1), reused by every read port.
- One natural sub-module, regfile_rdport: one read port with bypass, busy lookup and the optional output register, instantiated NRD times in a generate loop.

Test Plan:
- Reset then read, defaults: hold rst_n=0 for 2 cycles, release, read all 32 addresses -> every rd_data = 0, every rd_busy = 0, any_busy = 0.
- Write and bypass (READ_REG=0): we0=1, wa0=5, wd0=0xDEADBEEF and rd_addr port0=5 in the same cycle -> rd_data port0 = 0xDEADBEEF in that cycle, and still 0xDEADBEEF next cycle with we0=0.
- Dual-write collision: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> register 7 reads 0x22 afterwards; the same-cycle bypass also returns 0x22.
- Register 0: we1=1, wa1=0, wd1=0xFFFFFFFF, and bsy_set=1, bsy_addr=0 -> register 0 reads 0, rd_busy = 0, any_busy = 0.
- Scoreboard:
  - bsy_set on address 9 -> the next cycle's read of 9 gives rd_busy=1 and any_busy=1.
  - Write 9 with 0x55 -> same-cycle rd_busy=0 (clear-bypass); busy bit is 0 after the edge.
  - Simultaneous bsy_set(9) and write(9, 0x66) -> busy stays 1 and register 9 = 0x66.
- READ_REG=1 latency and mid-operation reset:
  - rd_addr port1=3 after writing 0xA5 to register 3 -> rd_data port1 = 0xA5 exactly one cycle later.
  - Assert rst_n=0 while busy[3]=1 and we0=1 -> after the edge the register, busy bit and output register are all 0.
